count_mod_chain: RTL
====================

Name: count_mod_chain

Overview:
- Parametrised multi-digit modulo-RADIX counter; the next generation of the single-digit decade counter.
- Generalised to DIGITS cascaded digits and any RADIX.
- Adds up/down counting, synchronous clear, parallel load, terminal-count and carry-out for chaining, and a sticky wrap flag.
- Used for display timers, event tallies and divider chains in the lab system.

Parameters:
DIGITS, 2, number of cascaded digits (1..8)
RADIX, 10, modulus of every digit (2..2**DW)
DW, 4, bits per digit; must satisfy 2**DW >= RADIX

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
en  in  1  count enable; one step per clock while high
up  in  1  direction: 1 = increment, 0 = decrement
clr  in  1  synchronous clear to all-zero
load  in  1  synchronous parallel load from din
din  in  DIGITS*DW  load value; digit i = din[i*DW +: DW], digit 0 least significant
count  out  DIGITS*DW  current value, same packing as din
tc  out  1  terminal count: all digits at terminal value for the current direction
co  out  1  carry/borrow out for cascading: tc & en
wrap  out  1  sticky flag: a full-chain wrap has occurred since reset/clr

Behaviour:
- Reset (rst low, asynchronous, any time): count = 0, wrap = 0.
  - tc and co are combinational: tc = 1 only if up = 0 (count is all-zero); co = 0 because en is ignored in reset.
  - Reset release is not synchronised inside the block; the caller provides a synchronised deassert.
- Priority at each rising clk edge when rst is high: clr > load > en.
- clr = 1:
  - count <= 0, wrap <= 0.
  - load and en are ignored that cycle.
- load = 1 (and clr = 0):
  - Each digit <= its din slice.
  - Any slice >= RADIX is clamped to RADIX-1.
  - wrap is unchanged; en is ignored that cycle.
- en = 1 (and clr = 0, load = 0):
  - Up: digit 0 increments. Digit i increments only when digits 0..i-1 are all RADIX-1. A digit at RADIX-1 that steps goes to 0.
  - Down: digit 0 decrements. Digit i decrements only when digits 0..i-1 are all 0. A digit at 0 that steps goes to RADIX-1.
  - Full-chain wrap: up from all RADIX-1 gives all 0; down from all 0 gives all RADIX-1. On wrap, wrap <= 1.
- en = 0: hold all state.
- tc, combinational from the registered count and up:
  - up = 1: tc = 1 if every digit = RADIX-1.
  - up = 0: tc = 1 if every digit = 0.
- co = tc & en, combinational, in the same cycle as tc.
  - Drives the en input of the next chained instance, giving a synchronous cascade with no ripple clock.
- Latency:
  - count updates 1 clock after the qualifying edge.
  - tc/co follow count and up with zero cycles of latency.
- Direction change mid-count takes effect on the next enabled edge; tc re-evaluates immediately.
- Simultaneous load and en: load wins; no step is applied to the loaded value.
- Simultaneous clr and wrap condition: clr wins; wrap = 0.
- Internal digit state is never outside 0..RADIX-1, including after load.

Decomposition:
- Package count_pkg: DIGIT_T sized by DW, and a function clamp_digit(value, RADIX).
- One sub-module, count_digit: a single modulo-RADIX up/down digit.
  - Inputs: step, up, clr, load, ld_val.
  - Outputs: q, at_max, at_zero.
- Top level generates DIGITS instances and ANDs at_max/at_zero prefixes to form per-digit step enables, tc and co.

Test Plan:
1. Defaults, rst pulsed low mid-count at value 47 -> count = 0 asynchronously before the next edge; wrap = 0; with up = 1, tc = 0.
2. up = 1, en = 1 from 0 for 100 clocks:
   - count passes 09 -> 10 and 98 -> 99.
   - At 99, tc = co = 1 for exactly that cycle.
   - Next edge gives 00, wrap = 1; co returns to 0.
3. up = 0, en = 1 from 10 -> next 09; continue to 00 (tc = 1) -> then 99, wrap = 1.
4. Load:
   - load = 1 with din = 0x3C (digit 0 = 12, invalid) -> count = 0x39.
   - load and en high together -> count exactly equals clamped din, no step.
5. Priority: clr = load = en = 1 at count 55, wrap = 1 -> count = 0, wrap = 0.
6. Two instances chained (co -> en of upper), DIGITS = 1, RADIX = 6, up = 1, 40 clocks:
   - Upper increments exactly once per 6 lower steps.
   - Lower sequence is 0..5 repeating.
   - Upper wraps after 36 steps.

Source files
------------

// File: rtl/count_pkg.sv
// Shared types and helpers for the modulo-RADIX counter chain.
// Provides the default digit type and the load clamp function.
package count_pkg;

  localparam int DW_DEF = 4;

  typedef logic [DW_DEF-1:0] DIGIT_T;

  function automatic int unsigned clamp_digit(
    input int unsigned value,
    input int unsigned radix
  );
    return (value >= radix) ? radix - 1 : value;
  endfunction

endpackage

// File: rtl/count_digit.sv
// One modulo-RADIX up/down digit with clear and clamped load.
// Ports: clk, rst (async low), step, up, clr, load, ld_val -> q, at_max, at_zero.
module count_digit
  import count_pkg::*;
#(
  parameter int RADIX = 10,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          up,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  output logic [DW-1:0] q,
  output logic          at_max,
  output logic          at_zero
);

  localparam logic [DW-1:0] MAXV = DW'(RADIX - 1);

  logic [DW-1:0] ld_clamped;

  assign ld_clamped = DW'(clamp_digit(32'(ld_val), RADIX));
  assign at_max     = (q == MAXV);
  assign at_zero    = (q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= ld_clamped;
    end else if (step) begin
      if (up) q <= at_max  ? '0   : q + 1'b1;
      else    q <= at_zero ? MAXV : q - 1'b1;
    end
  end

endmodule

// File: rtl/count_mod_chain.sv
// Multi-digit modulo-RADIX up/down counter with load, clear and cascade.
// Ports: clk, rst, en, up, clr, load, din -> count, tc, co, wrap.
module count_mod_chain
  import count_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int RADIX  = 10,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] din,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 co,
  output logic                 wrap
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] step;

  assign term = up ? at_max : at_zero;

  // Digit i steps only when every lower digit sits at its terminal value.
  always_comb begin
    logic acc;
    step = '0;
    acc  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = en & acc;
      acc     = acc & term[i];
    end
    tc = acc;
  end

  // en is ignored while reset is held.
  assign co = tc & en & rst;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    count_digit #(
      .RADIX(RADIX),
      .DW   (DW)
    ) u_digit (
      .clk    (clk),
      .rst    (rst),
      .step   (step[g]),
      .up     (up),
      .clr    (clr),
      .load   (load),
      .ld_val (din[g*DW +: DW]),
      .q      (count[g*DW +: DW]),
      .at_max (at_max[g]),
      .at_zero(at_zero[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else if (clr) begin
      wrap <= 1'b0;
    end else if (!load && en && tc) begin
      wrap <= 1'b1;
    end
  end

endmodule
